// File: rtl/oam_memory.sv
// Object Attribute Memory for the sprite engine.
// 64 x 32-bit words held in flops so reset can clear them. The write port
// takes one 16-bit halfword per cycle; the read port returns one full word
// per cycle with a single cycle of latency. Halfword 2k is the low half of
// word k, and halfword 2k+1 is the high half.
module oam_memory #(
   parameter int NUM_WORDS    = 64,
   parameter int READ_ADDR_W  = $clog2(NUM_WORDS),
   parameter int WRITE_ADDR_W = READ_ADDR_W + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    write_enable,
   input  logic [WRITE_ADDR_W-1:0] write_addr,
   input  logic [15:0]             write_data,
   input  logic [READ_ADDR_W-1:0]  read_addr,
   output logic [31:0]             read_data
);

   logic [31:0]            mem [NUM_WORDS];
   logic [READ_ADDR_W-1:0] write_word;
   logic                   write_hi;

   assign write_word = write_addr[WRITE_ADDR_W-1:1];
   assign write_hi   = write_addr[0];

   // Storage: async clear, then write one half of the addressed word and leave the other half unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      end else if (write_enable) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (write_word == READ_ADDR_W'(i)) begin
               if (write_hi) mem[i][31:16] <= write_data;
               else          mem[i][15:0]  <= write_data;
            end
         end
      end
   end

   // Registered read: the nonblocking update returns the pre-write contents when a write hits the same word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) read_data <= '0;
      else        read_data <= mem[read_addr];
   end

endmodule

// File: tb/tb_oam_memory.sv
// Self-checking bench for oam_memory: directed scenarios plus randomized
// traffic checked against a halfword-array reference model.
module tb_oam_memory;

   logic        clk;
   logic        rst_n;
   logic        write_enable;
   logic [6:0]  write_addr;
   logic [15:0] write_data;
   logic [5:0]  read_addr;
   logic [31:0] read_data;

   int checks = 0;
   int errors = 0;

   // Reference model: 128 halfwords; word k is {half[2k+1], half[2k]}
   logic [15:0] half_m [128];
   logic [31:0] exp_rd;

   oam_memory dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_addr    (read_addr),
      .read_data    (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_word(input int k);
      return {half_m[2*k+1], half_m[2*k]};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 128; i++) half_m[i] = 16'h0;
   endtask

   // One clock: drive at negedge, update the model at posedge, land #1 after the edge
   task automatic step(input logic we, input logic [6:0] wa, input logic [15:0] wd,
                       input logic [5:0] ra);
      @(negedge clk);
      write_enable = we;
      write_addr   = wa;
      write_data   = wd;
      read_addr    = ra;
      @(posedge clk);
      exp_rd = model_word(int'(ra));
      if (we && rst_n) half_m[wa] = wd;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; write_enable = 1'b1; write_addr = 7'd3; write_data = 16'hBEEF; read_addr = 6'd1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         errors++; $display("FAIL reset_hold got=%h exp=%h", read_data, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      write_enable = 1'b0;
      for (int a = 0; a < 64; a++) begin
         step(1'b0, 7'd0, 16'h0, 6'(a));
         checks++;
         if (read_data !== 32'h0) begin
            errors++; $display("FAIL reset_sweep addr=%0d got=%h exp=%h", a, read_data, 32'h0);
         end
      end
   endtask

   task automatic test_packing();
      step(1'b1, 7'd0, 16'h1234, 6'd0);
      step(1'b1, 7'd1, 16'h5678, 6'd0);
      step(1'b1, 7'd2, 16'h9876, 6'd0);
      step(1'b1, 7'd3, 16'h5432, 6'd0);
      step(1'b0, 7'd0, 16'h0, 6'd0);
      checks++;
      if (read_data !== 32'h5678_1234) begin
         errors++; $display("FAIL pack_word0 got=%h exp=%h", read_data, 32'h5678_1234);
      end
      step(1'b0, 7'd0, 16'h0, 6'd1);
      checks++;
      if (read_data !== 32'h5432_9876) begin
         errors++; $display("FAIL pack_word1 got=%h exp=%h", read_data, 32'h5432_9876);
      end
   endtask

   task automatic test_partial();
      step(1'b1, 7'd3, 16'hABCD, 6'd1);
      step(1'b0, 7'd0, 16'h0, 6'd1);
      checks++;
      if (read_data !== 32'hABCD_9876) begin
         errors++; $display("FAIL partial_word1 got=%h exp=%h", read_data, 32'hABCD_9876);
      end
      step(1'b0, 7'd0, 16'h0, 6'd0);
      checks++;
      if (read_data !== 32'h5678_1234) begin
         errors++; $display("FAIL partial_word0 got=%h exp=%h", read_data, 32'h5678_1234);
      end
   endtask

   task automatic test_write_disable();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 7'd0, 16'hFFFF, 6'd0);
         checks++;
         if (read_data !== 32'h5678_1234) begin
            errors++; $display("FAIL wr_disable cyc=%0d got=%h exp=%h", i, read_data, 32'h5678_1234);
         end
      end
   endtask

   task automatic test_collision();
      step(1'b1, 7'd10, 16'h1111, 6'd5);
      checks++;
      if (read_data !== 32'h0000_0000) begin
         errors++; $display("FAIL collision_old got=%h exp=%h", read_data, 32'h0);
      end
      step(1'b0, 7'd0, 16'h0, 6'd5);
      checks++;
      if (read_data !== 32'h0000_1111) begin
         errors++; $display("FAIL collision_new got=%h exp=%h", read_data, 32'h0000_1111);
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [6:0]  wa;
      logic [15:0] wd;
      logic [5:0]  ra;
      for (int i = 0; i < 400; i++) begin
         we = ($urandom_range(0, 3) != 0);
         wa = 7'($urandom_range(0, 127));
         wd = 16'($urandom);
         ra = ($urandom_range(0, 4) == 0) ? wa[6:1] : 6'($urandom_range(0, 63));
         step(we, wa, wd, ra);
         checks++;
         if (read_data !== exp_rd) begin
            errors++; $display("FAIL random i=%0d ra=%0d got=%h exp=%h", i, ra, read_data, exp_rd);
         end
      end
      // Full sweep so every word's final contents are compared against the model
      for (int a = 0; a < 64; a++) begin
         step(1'b0, 7'd0, 16'h0, 6'(a));
         checks++;
         if (read_data !== exp_rd) begin
            errors++; $display("FAIL random_sweep addr=%0d got=%h exp=%h", a, read_data, exp_rd);
         end
      end
   endtask

   task automatic test_async_reset();
      // Make sure the word under the read port is nonzero before the pulse
      step(1'b1, 7'd40, 16'hC0DE, 6'd20);
      step(1'b1, 7'd41, 16'hFACE, 6'd20);
      step(1'b0, 7'd0, 16'h0, 6'd20);
      checks++;
      if (read_data !== 32'hFACE_C0DE) begin
         errors++; $display("FAIL async_pre got=%h exp=%h", read_data, 32'hFACE_C0DE);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         errors++; $display("FAIL async_immediate got=%h exp=%h", read_data, 32'h0);
      end
      // Writes attempted while in reset must be discarded
      write_enable = 1'b1; write_addr = 7'd41; write_data = 16'h7777;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (read_data !== 32'h0) begin
         errors++; $display("FAIL async_hold got=%h exp=%h", read_data, 32'h0);
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      write_enable = 1'b0;
      for (int a = 0; a < 64; a++) begin
         step(1'b0, 7'd0, 16'h0, 6'(a));
         checks++;
         if (read_data !== 32'h0) begin
            errors++; $display("FAIL async_sweep addr=%0d got=%h exp=%h", a, read_data, 32'h0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_packing();
      test_partial();
      test_write_disable();
      test_collision();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
